// File: rtl/evermoore_isa_pkg.sv
// ---------------------------------------------------------------------------
// evermoore_isa_pkg
// Shared ISA definitions for the Evermoore program encoder: the op_t
// instruction select, per-format prefixes, sub-opcodes, condition codes
// and the loader FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package evermoore_isa_pkg;

    typedef enum logic [3:0] {
        JMR   = 4'd0,
        INC   = 4'd1,
        DEC   = 4'd2,
        SIM   = 4'd3,
        ADD   = 4'd4,
        SUB   = 4'd5,
        MOV   = 4'd6,
        PUSH  = 4'd7,
        POP   = 4'd8,
        STORE = 4'd9,
        MUL   = 4'd10,
        JMD   = 4'd11,
        CALL  = 4'd12,
        LDA   = 4'd13,
        RTN   = 4'd14,
        STP   = 4'd15
    } op_t;

    // Loader FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCEPT    = 3'd1,
        WRITE     = 3'd2,
        WRITE_IMM = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Condition field values.
    localparam logic [3:0] COND_ALWAYS  = 4'b0110;
    localparam logic [3:0] COND_INVALID = 4'b1110;

    // Format prefixes.
    localparam logic [2:0] PFX_SINGLE = 3'b000;
    localparam logic [1:0] PFX_DOUBLE = 2'b01;
    localparam logic [2:0] PFX_MUL    = 3'b100;
    localparam logic [4:0] PFX_CTRL   = 5'b11110;

    // Single-register sub-opcodes, bits [12:7].
    localparam logic [5:0] SUB_JMR = 6'b000000;
    localparam logic [5:0] SUB_INC = 6'b001000;
    localparam logic [5:0] SUB_DEC = 6'b001001;
    localparam logic [5:0] SUB_SIM = 6'b001100;

    // Double-register sub-opcodes, bits [13:10].
    localparam logic [3:0] SUB_ADD   = 4'b0000;
    localparam logic [3:0] SUB_SUB   = 4'b0010;
    localparam logic [3:0] SUB_MOV   = 4'b0110;
    localparam logic [3:0] SUB_PUSH  = 4'b1000;
    localparam logic [3:0] SUB_POP   = 4'b1010;
    localparam logic [3:0] SUB_STORE = 4'b1011;

    // Direct-address opcodes, bits [15:12].
    localparam logic [3:0] DIR_JMD  = 4'b1100;
    localparam logic [3:0] DIR_CALL = 4'b1101;
    localparam logic [3:0] DIR_LDA  = 4'b1110;

    // Control sub-opcodes, bits [10:4].
    localparam logic [6:0] CTRL_RTN = 7'b0000000;
    localparam logic [6:0] CTRL_STP = 7'b0000001;

    // Session word counter saturates at one full RAM's worth of words.
    localparam logic [12:0] WORD_COUNT_MAX = 13'd4096;

    // Direct ops carry a 12-bit address in place of a condition field.
    function automatic logic is_direct(input op_t op);
        return (op == JMD) || (op == CALL) || (op == LDA);
    endfunction

endpackage

// File: rtl/evermoore_program_encoder_instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
// Combinational field packer: turns one decoded request into a 16-bit
// instruction word and flags requests that must not be written.
// Ports:
//   i_op      op select (op_t)
//   i_cond    condition field
//   i_rd      destination register
//   i_rs1     source register 1
//   i_rs2     source register 2
//   i_imm     immediate / direct address
//   o_word    packed instruction word
//   o_illegal request is illegal (invalid condition or oversized address)
// ---------------------------------------------------------------------------
module instr_pack
    import evermoore_isa_pkg::*;
(
    input  op_t         i_op,
    input  logic [3:0]  i_cond,
    input  logic [2:0]  i_rd,
    input  logic [2:0]  i_rs1,
    input  logic [2:0]  i_rs2,
    input  logic [15:0] i_imm,
    output logic [15:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word = 16'h0000;
        case (i_op)
            JMR:     o_word = {PFX_SINGLE, SUB_JMR, i_cond, i_rd};
            INC:     o_word = {PFX_SINGLE, SUB_INC, i_cond, i_rd};
            DEC:     o_word = {PFX_SINGLE, SUB_DEC, i_cond, i_rd};
            SIM:     o_word = {PFX_SINGLE, SUB_SIM, i_cond, i_rd};
            ADD:     o_word = {PFX_DOUBLE, SUB_ADD,   i_cond, i_rd, i_rs1};
            SUB:     o_word = {PFX_DOUBLE, SUB_SUB,   i_cond, i_rd, i_rs1};
            MOV:     o_word = {PFX_DOUBLE, SUB_MOV,   i_cond, i_rd, i_rs1};
            PUSH:    o_word = {PFX_DOUBLE, SUB_PUSH,  i_cond, i_rd, i_rs1};
            POP:     o_word = {PFX_DOUBLE, SUB_POP,   i_cond, i_rd, i_rs1};
            STORE:   o_word = {PFX_DOUBLE, SUB_STORE, i_cond, i_rd, i_rs1};
            MUL:     o_word = {PFX_MUL, i_cond, i_rd, i_rs2, i_rs1};
            JMD:     o_word = {DIR_JMD,  i_imm[11:0]};
            CALL:    o_word = {DIR_CALL, i_imm[11:0]};
            LDA:     o_word = {DIR_LDA,  i_imm[11:0]};
            RTN:     o_word = {PFX_CTRL, CTRL_RTN, i_cond};
            STP:     o_word = {PFX_CTRL, CTRL_STP, i_cond};
            default: o_word = 16'h0000;
        endcase
    end

    // Direct ops only have 12 address bits, so a non-zero upper nibble
    // cannot be encoded; every other op is conditional.
    always_comb begin
        o_illegal = 1'b0;
        if (is_direct(i_op)) begin
            o_illegal = |i_imm[15:12];
        end else begin
            o_illegal = (i_cond == COND_INVALID);
        end
    end

endmodule

// File: rtl/evermoore_program_encoder.sv
// ---------------------------------------------------------------------------
// evermoore_program_encoder
// Accepts instruction requests, encodes them and writes them to program RAM
// from base_addr upward, one word per two cycles (SIM emits two words).
// Handshake: a request transfers on a rising clock edge where
// in_valid & in_ready; in_ready is high only while waiting for a request,
// and the word is written (ram_wren) in the cycle right after the transfer.
// Ports:
//   clock, reset_n          clock, async active-low reset
//   start, base_addr        open a session at base_addr (ignored when busy)
//   in_valid/in_ready       request handshake
//   in_op..in_imm, in_last  request fields; in_last closes the session
//   ram_addr/data/wren      program-RAM write port
//   busy, done, error       session status (error sticky until next start)
//   word_count              words written this session (saturating)
// ---------------------------------------------------------------------------
module evermoore_program_encoder
    import evermoore_isa_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [3:0]  in_cond,
    input  logic [2:0]  in_rd,
    input  logic [2:0]  in_rs1,
    input  logic [2:0]  in_rs2,
    input  logic [15:0] in_imm,
    input  logic        in_last,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [12:0] word_count
);

    state_t      r_state;
    logic [11:0] r_ram_addr;
    logic [15:0] r_ram_data;
    logic        r_ram_wren;
    logic        r_in_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [12:0] r_word_count;
    logic [15:0] r_imm;
    logic        r_is_sim;
    logic        r_last;

    logic [15:0] w_word;
    logic        w_illegal;
    op_t         w_op;

    assign w_op = op_t'(in_op);

    instr_pack u_instr_pack (
        .i_op      (w_op),
        .i_cond    (in_cond),
        .i_rd      (in_rd),
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_ram_addr   <= 12'h000;
            r_ram_data   <= 16'h0000;
            r_ram_wren   <= 1'b0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= 13'd0;
            r_imm        <= 16'h0000;
            r_is_sim     <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ram_addr   <= base_addr;
                        r_word_count <= 13'd0;
                        r_error      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_in_ready   <= 1'b1;
                        r_state      <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        if (w_illegal) begin
                            // Nothing is written; only a last request ends the session.
                            r_error <= 1'b1;
                            if (in_last) begin
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                                r_state    <= DONE;
                            end
                        end else begin
                            r_ram_data <= w_word;
                            r_imm      <= in_imm;
                            r_is_sim   <= (w_op == SIM);
                            r_last     <= in_last;
                            r_in_ready <= 1'b0;
                            r_ram_wren <= 1'b1;
                            r_state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_ram_addr <= r_ram_addr + 12'd1;
                    if (r_word_count != WORD_COUNT_MAX) begin
                        r_word_count <= r_word_count + 13'd1;
                    end
                    if (r_is_sim) begin
                        // Keep the strobe high for the trailing immediate word.
                        r_ram_data <= r_imm;
                        r_state    <= WRITE_IMM;
                    end else if (r_last) begin
                        r_ram_wren <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_ram_wren <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= ACCEPT;
                    end
                end
                WRITE_IMM: begin
                    r_ram_addr <= r_ram_addr + 12'd1;
                    if (r_word_count != WORD_COUNT_MAX) begin
                        r_word_count <= r_word_count + 13'd1;
                    end
                    r_ram_wren <= 1'b0;
                    if (r_last) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= ACCEPT;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ram_wren <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign ram_addr   = r_ram_addr;
    assign ram_data   = r_ram_data;
    assign ram_wren   = r_ram_wren;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;

endmodule

// File: doc/evermoore_program_encoder.md
EVERMOORE_PROGRAM_ENCODER -- requirements
Module: evermoore_program_encoder

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Ports (name  dir  width  meaning):
- clock  in  1  system clock, rising edge.
- reset_n  in  1  async active-low reset.
- start  in  1  begin a load session at base_addr.
- base_addr  in  12  first program-RAM address.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder accepts a request this cycle.
- in_op  in  4  op select, enum op_t.
- in_cond  in  4  condition field.
- in_rd  in  3  destination register.
- in_rs1  in  3  source register 1.
- in_rs2  in  3  source register 2.
- in_imm  in  16  immediate or direct address.
- in_last  in  1  final request of the session.
- ram_addr  out  12  program-RAM write address.
- ram_data  out  16  encoded word.
- ram_wren  out  1  one-cycle write strobe.
- busy  out  1  session active.
- done  out  1  one-cycle pulse at session end.
- error  out  1  sticky error, cleared by start.
- word_count  out  13  words written this session.

Function
REQ-003 op_t SHALL be: JMR=0, INC=1, DEC=2, SIM=3, ADD=4, SUB=5, MOV=6, PUSH=7, POP=8, STORE=9, MUL=10, JMD=11, CALL=12, LDA=13, RTN=14, STP=15.
REQ-004 Single-reg ops SHALL encode [15:13]=000, [12:7]=JMR 000000 / INC 001000 / DEC 001001 / SIM 001100, [6:3]=cond, [2:0]=rd.
REQ-005 Double-reg ops SHALL encode [15:14]=01, [13:10]=ADD 0000 / SUB 0010 / MOV 0110 / PUSH 1000 / POP 1010 / STORE 1011, [9:6]=cond, [5:3]=rd, [2:0]=rs1.
REQ-006 MUL SHALL encode [15:13]=100, [12:9]=cond, [8:6]=rd, [5:3]=rs2, [2:0]=rs1.
REQ-007 Direct ops SHALL encode [15:12]=JMD 1100 / CALL 1101 / LDA 1110, [11:0]=in_imm[11:0]; in_cond is ignored.
REQ-008 Control ops SHALL encode [15:11]=11110, [10:4]=RTN 0000000 / STP 0000001, [3:0]=cond.
REQ-009 SIM SHALL emit two consecutive words: the instruction, then in_imm[15:0].
REQ-010 FSM states SHALL be IDLE, ACCEPT, WRITE, WRITE_IMM and DONE.
- IDLE: on start, load ram_addr=base_addr, clear word_count and error, go to ACCEPT.
- ACCEPT: in_ready=1; on handshake, register word and flags; go to WRITE, or to DONE/ACCEPT if the request is illegal.
- WRITE: ram_wren=1; go to WRITE_IMM (SIM), else DONE if last, else ACCEPT.
- WRITE_IMM: ram_wren=1 with the immediate; go to DONE if last, else ACCEPT.
- DONE: done=1 for one cycle; go to IDLE.
REQ-011 in_ready SHALL be 1 only in ACCEPT; the handshake is in_valid & in_ready.
REQ-012 Latency SHALL be one cycle from handshake to ram_wren; sustained rate is one word per two cycles.
REQ-013 After each write, ram_addr and word_count SHALL increment; ram_addr wraps 4095->0; word_count saturates at 4096.
REQ-014 Illegal requests SHALL set error and write nothing:
- cond==1110 on a conditional op.
- in_imm[15:12]!=0 on JMD, CALL or LDA.
REQ-015 An illegal request carrying in_last SHALL still end the session via DONE.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 busy SHALL be 1 in every state except IDLE.

Reset
REQ-018 Reset SHALL force the following, immediately and from any state, including between WRITE and WRITE_IMM:
- state IDLE.
- in_ready=0, ram_wren=0, done=0, busy=0, error=0.
- ram_addr=0, ram_data=0, word_count=0.
REQ-019 No write SHALL occur after reset until a new start.

Structure
REQ-020 op_t, the format prefixes, the sub-opcode constants and the condition constants (ALWAYS=0110, INVALID=1110) SHALL live in the shared package evermoore_isa_pkg.
REQ-021 Field packing SHALL be a combinational sub-module, instr_pack: op, cond, regs and imm in; word and illegal out. The FSM stays in the top module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Scenario 1: start base=0x010; request ADD cond=0110 rd=2 rs1=5 -> one write, ram_addr=0x010, ram_data=0x4195.
- Scenario 2: SIM rd=3 cond=0110 imm=0xBEEF, last -> writes 0x0633 then 0xBEEF at consecutive addresses, then done, word_count=2.
- Scenario 3: base=0xFFF; request JMD imm=0x0ABC, then RTN cond=0110 -> 0xCABC at 0xFFF, then 0xF006 at 0x000 (wrap).
- Scenario 4: MUL cond=1110, last -> no ram_wren, error=1, done pulse; next start clears error.
- Scenario 5: CALL imm=0x1000 -> error=1, no write; a following STP cond=0110 -> 0xF016 written.
- Scenario 6: assert reset_n low during WRITE_IMM -> ram_wren=0 at once; all outputs at reset values; no immediate word written after release.
